accumulator_rmw: RTL and testbench

//   Double-buffered (ping-pong) output accumulator between systolic array and VPU.

---
 rtl/accumulator_rmw.sv | 163 ++++++++++++++++
 tb/tb_accumulator_rmw.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_rmw.sv
// Ping-pong output accumulator between the systolic array and the VPU.
// The array overwrites or saturating-accumulates into the write bank while the VPU reads the other bank.
module accumulator_rmw #(
    parameter int DATA_WIDTH   = 32,
    parameter int ARRAY_SIZE   = 3,
    parameter int BUFFER_DEPTH = 256,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic                             wr_acc,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] wr_data,
    output logic                             wr_ready,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] rd_data,
    output logic                             rd_valid,
    input  logic                             swap_req,
    input  logic                             clear_req,
    output logic                             wr_bank,
    output logic [ARRAY_SIZE-1:0]            sat_flag,
    output logic                             acc_busy
);
    localparam int LW = DATA_WIDTH * ARRAY_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BUFFER_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    state_e                  state_q, state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    swap_pend_q, swap_pend_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ARRAY_SIZE-1:0]   sat_q, sat_d;
    logic                    s1_vld_q, s1_acc_q;
    logic [ADDR_WIDTH-1:0]   s1_addr_q;
    logic [LW-1:0]           s1_data_q, s1_old_q, s1_old_d;
    logic [LW-1:0]           s1_result;
    logic [ARRAY_SIZE-1:0]   s1_sat;
    logic [LW-1:0]           rd_data_q;
    logic                    rd_valid_q;
    logic                    accept, clr_wr, mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [LW-1:0]           mem_wdata;

    logic [LW-1:0] mem [2][BUFFER_DEPTH];

    assign accept = wr_en && (state_q == IDLE);

    // Lane-wise saturating add of the staged write onto the old value.
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        logic [DATA_WIDTH:0]   sum;
        logic [DATA_WIDTH-1:0] a, b;
        logic                  ovf;
        assign a   = s1_old_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign b   = s1_data_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        assign ovf = s1_acc_q && (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]);
        assign s1_sat[g] = ovf;
        assign s1_result[g*DATA_WIDTH +: DATA_WIDTH] =
            !s1_acc_q ? b :
            !ovf      ? sum[DATA_WIDTH-1:0] :
            sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    // Bypass the in-flight result so back-to-back ops to one address chain correctly.
    assign s1_old_d = (s1_vld_q && (s1_addr_q == wr_addr)) ? s1_result : mem[wr_bank_q][wr_addr];

    assign clr_wr    = (state_q == CLEAR) && !s1_vld_q;
    assign mem_we    = s1_vld_q || clr_wr;
    assign mem_waddr = s1_vld_q ? s1_addr_q : clr_cnt_q;
    assign mem_wdata = s1_vld_q ? s1_result : '0;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_bank_q][mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        swap_pend_d = swap_pend_q;
        clr_cnt_d   = clr_cnt_q;
        sat_d       = sat_q | (s1_vld_q ? s1_sat : '0);
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    swap_pend_d = swap_pend_q | swap_req;
                end else if (swap_req || swap_pend_q) begin
                    state_d     = DRAIN;
                    swap_pend_d = 1'b0;
                end
            end
            DRAIN: begin
                if (swap_req) swap_pend_d = 1'b1;
                if (!s1_vld_q) begin
                    wr_bank_d = ~wr_bank_q;
                    state_d   = IDLE;
                end
            end
            CLEAR: begin
                if (swap_req) swap_pend_d = 1'b1;
                if (clr_wr) begin
                    // Flags drop once any write accepted alongside clear_req has retired.
                    if (clr_cnt_q == '0) sat_d = '0;
                    if (clr_cnt_q == LAST) begin
                        if (swap_pend_q || swap_req) begin
                            state_d     = DRAIN;
                            swap_pend_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            swap_pend_q <= 1'b0;
            clr_cnt_q   <= '0;
            sat_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_old_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            swap_pend_q <= swap_pend_d;
            clr_cnt_q   <= clr_cnt_d;
            sat_q       <= sat_d;
            s1_vld_q    <= accept;
            if (accept) begin
                s1_acc_q  <= wr_acc;
                s1_addr_q <= wr_addr;
                s1_data_q <= wr_data;
                s1_old_q  <= s1_old_d;
            end
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem[~wr_bank_q][rd_addr];
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign acc_busy = (state_q != IDLE) || swap_pend_q;
    assign wr_bank  = wr_bank_q;
    assign sat_flag = sat_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_accumulator_rmw.sv
// Bench for accumulator_rmw: vector table of writes, read scoreboard, clear/swap/reset sequences.
module tb_accumulator_rmw;
    localparam int DW = 32, AS = 3, DEPTH = 256, AW = 8, LW = DW * AS;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          wr_en = 1'b0, wr_acc = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [LW-1:0] wr_data = '0;
    logic          rd_en = 1'b0, swap_req = 1'b0, clear_req = 1'b0;
    logic          wr_ready, rd_valid, wr_bank, acc_busy;
    logic [LW-1:0] rd_data;
    logic [AS-1:0] sat_flag;

    accumulator_rmw #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .swap_req(swap_req), .clear_req(clear_req),
        .wr_bank(wr_bank), .sat_flag(sat_flag), .acc_busy(acc_busy));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [LW-1:0] data; int due; } rd_exp_t;
    rd_exp_t rq[$];

    typedef struct { logic acc; logic [AW-1:0] addr; logic [LW-1:0] data; logic chk; logic [LW-1:0] exp; } vec_t;
    vec_t tbl[17];

    function automatic logic [LW-1:0] L(input logic [31:0] a2, input logic [31:0] a1, input logic [31:0] a0);
        return {a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (rst_n && rd_valid) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected_valid", 1'b1, 1'b0);
            end else begin
                e = rq.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_latency", cyc, e.due);
            end
        end
    end

    task automatic idle_in();
        @(negedge clk);
        wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wr(input logic acc, input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_acc = acc; wr_addr = a; wr_data = d;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [LW-1:0] exp);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        rq.push_back('{exp, cyc + 1});
    endtask

    task automatic drain_reads();
        for (int i = 0; i < 10 && rq.size() != 0; i++) @(negedge clk);
        chk("rd_queue_drained", rq.size(), 0);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound && acc_busy; i++) @(negedge clk);
        chk("idle_within_bound", (i < bound), 1'b1);
    endtask

    task automatic swap(input logic exp_bank);
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0;
        wait_idle(10);
        chk("swap_bank", wr_bank, exp_bank);
    endtask

    task automatic busy_count(output int n, output int nr, output int tog);
        logic b0;
        n = 0; nr = 0; tog = 0; b0 = wr_bank;
        while (acc_busy && n < 400) begin
            n++;
            if (!wr_ready) nr++;
            @(negedge clk);
            if (acc_busy && wr_bank != b0) begin tog++; b0 = wr_bank; end
        end
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1'b1);
        chk({tag, "_acc_busy"}, acc_busy, 1'b0);
        chk({tag, "_wr_bank"}, wr_bank, 1'b0);
        chk({tag, "_sat_flag"}, sat_flag, 3'b000);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_data"}, rd_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int n, nr, tog;
        tbl[0]  = '{1'b0, 8'd5,   L(32'h33, 32'h22, 32'h11), 1'b1, L(32'h33, 32'h22, 32'h11)};
        tbl[1]  = '{1'b0, 8'd3,   L(10, 10, 10), 1'b0, '0};
        tbl[2]  = '{1'b1, 8'd3,   L(5, 5, 5), 1'b0, '0};
        tbl[3]  = '{1'b1, 8'd3,   L(7, 7, 7), 1'b1, L(22, 22, 22)};
        tbl[4]  = '{1'b0, 8'd7,   L(0, 0, 32'h7FFFFFF0), 1'b0, '0};
        tbl[5]  = '{1'b1, 8'd7,   L(0, 0, 32'h20), 1'b1, L(0, 0, 32'h7FFFFFFF)};
        tbl[6]  = '{1'b0, 8'd8,   L(0, 0, 32'h80000010), 1'b0, '0};
        tbl[7]  = '{1'b1, 8'd8,   L(0, 0, 32'hFFFFFFE0), 1'b1, L(0, 0, 32'h80000000)};
        tbl[8]  = '{1'b0, 8'd9,   L(32'h80000000, 32'd100, 32'h40000000), 1'b0, '0};
        tbl[9]  = '{1'b1, 8'd9,   L(32'hFFFFFFFF, 32'hFFFFFF38, 32'h3FFFFFFF), 1'b1,
                    L(32'h80000000, 32'hFFFFFF9C, 32'h7FFFFFFF)};
        tbl[10] = '{1'b0, 8'd10,  L(1, 2, 3), 1'b0, '0};
        tbl[11] = '{1'b0, 8'd11,  L(4, 5, 6), 1'b0, '0};
        tbl[12] = '{1'b1, 8'd10,  L(1, 1, 1), 1'b1, L(2, 3, 4)};
        tbl[13] = '{1'b1, 8'd11,  L(1, 1, 1), 1'b1, L(5, 6, 7)};
        tbl[14] = '{1'b0, 8'd255, L(32'hDEADBEEF, 1, 32'hFFFFFFFF), 1'b0, '0};
        tbl[15] = '{1'b1, 8'd255, L(1, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1, L(32'hDEADBEF0, 0, 32'hFFFFFFFE)};
        tbl[16] = '{1'b0, 8'd0,   L(32'hAAAA, 32'hBBBB, 32'hCCCC), 1'b1, L(32'hAAAA, 32'hBBBB, 32'hCCCC)};

        repeat (2) @(negedge clk);
        check_rst("reset");
        rst_n = 1'b1;

        // Table: back-to-back overwrite/accumulate into bank 0, then read back from the other side.
        for (int i = 0; i < 17; i++) wr(tbl[i].acc, tbl[i].addr, tbl[i].data);
        idle_in();
        repeat (2) @(negedge clk);
        chk("sat_after_table", sat_flag, 3'b101);
        swap(1'b1);
        for (int i = 0; i < 17; i++) if (tbl[i].chk) rd(tbl[i].addr, tbl[i].exp);
        idle_in();
        drain_reads();
        repeat (3) @(negedge clk);
        chk("rd_data_hold", rd_data, L(32'hAAAA, 32'hBBBB, 32'hCCCC));
        chk("rd_valid_low", rd_valid, 1'b0);

        // Fill bank 1, saturate lane 1, then sweep-clear it while reading bank 0.
        wr(1'b0, 8'd0, L(1, 2, 3));
        wr(1'b0, 8'd128, L(9, 9, 9));
        wr(1'b0, 8'd255, L(5, 5, 5));
        wr(1'b0, 8'd50, L(0, 32'h7FFFFFFF, 0));
        wr(1'b1, 8'd50, L(0, 1, 0));
        idle_in();
        repeat (2) @(negedge clk);
        chk("sat_before_clear", sat_flag, 3'b111);
        @(negedge clk);
        clear_req = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
        rq.push_back('{L(32'h33, 32'h22, 32'h11), cyc + 1});
        @(negedge clk);
        clear_req = 1'b0; rd_en = 1'b0;
        busy_count(n, nr, tog);
        chk("clear_busy_cycles", n, 256);
        chk("clear_not_ready_cycles", nr, 256);
        chk("sat_after_clear", sat_flag, 3'b000);
        chk("clear_no_toggle", wr_bank, 1'b1);
        swap(1'b0);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a), '0);
        idle_in();
        drain_reads();

        // Write accepted alongside swap_req must land before the toggle.
        @(negedge clk);
        wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 8'd20; wr_data = L(7, 8, 9); swap_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b0;
        chk("drain_not_ready", wr_ready, 1'b0);
        wait_idle(10);
        chk("wr_swap_bank", wr_bank, 1'b1);
        rd(8'd20, L(7, 8, 9));
        rd(8'd3, L(22, 22, 22));
        idle_in();
        drain_reads();

        // clear_req + swap_req together: full sweep, then exactly one toggle.
        wr(1'b0, 8'd60, L(5, 5, 5));
        @(negedge clk);
        wr_en = 1'b0; clear_req = 1'b1; swap_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0; swap_req = 1'b0;
        busy_count(n, nr, tog);
        chk("clrswap_busy_cycles", n, 257);
        chk("clrswap_early_toggle", tog, 0);
        chk("clrswap_bank", wr_bank, 1'b0);
        rd(8'd60, '0);
        rd(8'd0, '0);
        idle_in();
        drain_reads();

        // swap_req during CLEAR is deferred to a single toggle after the sweep.
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        repeat (10) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0;
        chk("deferred_busy", acc_busy, 1'b1);
        chk("deferred_bank_hold", wr_bank, 1'b0);
        busy_count(n, nr, tog);
        chk("deferred_early_toggle", tog, 0);
        chk("deferred_bank", wr_bank, 1'b1);
        repeat (5) @(negedge clk);
        chk("deferred_single_toggle", wr_bank, 1'b1);
        chk("deferred_idle", acc_busy, 1'b0);
        rd(8'd20, '0);
        rd(8'd3, '0);
        idle_in();
        drain_reads();

        // Reset while an accumulate is in flight.
        wr(1'b0, 8'd70, L(0, 0, 32'h7FFFFFFF));
        wr(1'b1, 8'd70, L(0, 0, 1));
        wr(1'b1, 8'd70, L(0, 0, 1));
        @(posedge clk);
        #1;
        chk("pre_rst_sat", sat_flag, 3'b001);
        rst_n = 1'b0;
        wr_en = 1'b0; wr_acc = 1'b0;
        #1;
        check_rst("rst_mid_acc");
        @(negedge clk); rst_n = 1'b1;

        // Writes resume cleanly; then reset in the middle of a clear sweep.
        wr(1'b0, 8'd40, L(1, 2, 3));
        wr(1'b1, 8'd40, L(1, 1, 1));
        idle_in();
        swap(1'b1);
        rd(8'd40, L(2, 3, 4));
        idle_in();
        drain_reads();
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_rst("rst_mid_clear");
        @(negedge clk); rst_n = 1'b1;
        wr(1'b0, 8'd41, L(32'h80000000, 0, 0));
        wr(1'b1, 8'd41, L(32'hFFFFFFFF, 3, 4));
        idle_in();
        repeat (2) @(negedge clk);
        chk("post_rst_sat", sat_flag, 3'b100);
        swap(1'b1);
        rd(8'd41, L(32'h80000000, 3, 4));
        idle_in();
        drain_reads();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
